// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter and sequencer sharing one DRAM channel between NREQ requesters.
// Latency: req sampled in cycle 0 -> gnt/mem_valid in cycle 1; response XFER_CYCLES+1 cycles after mem_done.
// Backpressure: bus_busy blocks new grants in IDLE and freezes XFER; one transaction outstanding at a time.
module mem_req_arbiter #(
  parameter int NREQ        = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int XFER_CYCLES = 10,
  parameter int TIMEOUT     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic               bus_busy,
  input  logic               mem_done,
  input  logic [DW-1:0]      mem_rdata,
  output logic [NREQ-1:0]    gnt,
  output logic               mem_valid,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic               taking,
  output logic               pop,
  output logic [NREQ-1:0]    rsp_valid,
  output logic               rsp_err,
  output logic [DW-1:0]      rsp_rdata,
  output logic               busy
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam int XW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_XFER,
    S_RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] win;
  logic          win_vld;
  logic [TW-1:0] timer;
  logic [XW-1:0] xcnt;
  logic          err;
  logic          first_xfer;
  logic          timer_last;
  logic          xcnt_last;

  assign timer_last = (timer == TW'(TIMEOUT - 1));
  assign xcnt_last  = (xcnt == XW'(XFER_CYCLES - 1));

  // Round-robin pick: smallest distance from ptr+1 among active requesters.
  always_comb begin
    int best_d;
    int d;
    win     = '0;
    win_vld = 1'b0;
    best_d  = NREQ;
    d       = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - 1 - int'(ptr)) % NREQ;
      if (req[i] && d < best_d) begin
        best_d  = d;
        win     = PW'(i);
        win_vld = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; done on the last WAIT cycle beats the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_vld && !bus_busy) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_done)        state_nxt = S_XFER;
        else if (timer_last) state_nxt = S_RESP;
      end
      S_XFER:  if (!bus_busy && xcnt_last) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command latch, counters, error flag and response data per state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= PW'(NREQ - 1);
      win_idx    <= '0;
      gnt        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      timer      <= '0;
      xcnt       <= '0;
      err        <= 1'b0;
      first_xfer <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld && !bus_busy) begin
            win_idx   <= win;
            gnt       <= NREQ'(1) << win;
            mem_we    <= req_we[win];
            mem_addr  <= req_addr[win*AW +: AW];
            mem_wdata <= req_wdata[win*DW +: DW];
          end
        end
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          if (mem_done) begin
            if (!mem_we) rsp_rdata <= mem_rdata;
            xcnt       <= '0;
            first_xfer <= 1'b1;
          end else if (timer_last) begin
            err <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_XFER: begin
          first_xfer <= 1'b0;
          if (!bus_busy && !xcnt_last) xcnt <= xcnt + XW'(1);
        end
        S_RESP: begin
          ptr <= win_idx;
          err <= 1'b0;
          gnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_valid = (state == S_ISSUE);
  assign taking    = (state == S_XFER);
  assign pop       = (state == S_XFER) && first_xfer;
  assign rsp_valid = (state == S_RESP) ? gnt : '0;
  assign rsp_err   = (state == S_RESP) && err;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: single read, alternation, timeout, bus_busy stalls,
// mid-transaction reset and a write; each transaction is traced cycle by cycle
// relative to the cycle the stimulus was applied.
module tb_mem_req_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int XC   = 10;
  localparam int TO   = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic               bus_busy;
  logic               mem_done;
  logic [DW-1:0]      mem_rdata;
  logic [NREQ-1:0]    gnt;
  logic               mem_valid;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               taking;
  logic               pop;
  logic [NREQ-1:0]    rsp_valid;
  logic               rsp_err;
  logic [DW-1:0]      rsp_rdata;
  logic               busy;

  mem_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .XFER_CYCLES(XC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .bus_busy(bus_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .gnt(gnt), .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .taking(taking), .pop(pop), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Trace of the last transaction, cycles relative to the call cycle (0).
  int          r_issue, r_pop, r_take_first, r_take_last, r_ntake, r_npop, r_nvalid, r_rsp_c;
  logic [1:0]  r_gnt, r_rsp;
  logic        r_err, r_we;
  logic [31:0] r_rdata, r_addr, r_wdata;

  // Runs one transaction: mem_done done_dly cycles after ISSUE (negative = never),
  // bus_busy high for bb_len cycles starting bb_start cycles after ISSUE.
  task automatic run_txn(input int done_dly, input logic [31:0] rdat, input int bb_start, input int bb_len);
    int c;
    bit fin;
    r_issue = -1; r_pop = -1; r_take_first = -1; r_take_last = -1;
    r_ntake = 0; r_npop = 0; r_nvalid = 0; r_rsp_c = -1;
    r_gnt = '0; r_rsp = '0; r_err = 1'b0; r_we = 1'b0;
    r_rdata = '0; r_addr = '0; r_wdata = '0;
    c = 0;
    fin = 1'b0;
    while (!fin) begin
      if (mem_valid) begin
        r_nvalid++;
        if (r_issue < 0) begin
          r_issue = c; r_gnt = gnt; r_we = mem_we; r_addr = mem_addr; r_wdata = mem_wdata;
        end
      end
      if (pop) begin r_npop++; r_pop = c; end
      if (taking) begin
        r_ntake++;
        if (r_take_first < 0) r_take_first = c;
        r_take_last = c;
      end
      if (r_issue >= 0 && rsp_valid != '0) begin
        r_rsp_c = c; r_rsp = rsp_valid; r_err = rsp_err; r_rdata = rsp_rdata; fin = 1'b1;
      end
      mem_done  = (r_issue >= 0 && done_dly >= 0 && c == r_issue + done_dly);
      mem_rdata = mem_done ? rdat : 32'h0BAD_0BAD;
      bus_busy  = (r_issue >= 0 && c >= r_issue + bb_start && c < r_issue + bb_start + bb_len);
      if (!fin) begin
        step();
        c++;
        if (c > 300) begin
          check("txn_timeout", 1, 0);
          fin = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    bus_busy = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    rst_n = 1'b0;
    step(); step();
    check("reset_ctl", {gnt, mem_valid, mem_we, taking, pop, rsp_valid, rsp_err, busy}, '0);
    check("reset_data", {mem_addr, mem_wdata, rsp_rdata}, '0);
    rst_n = 1'b1;
    step();

    // Single read from requester 0, done in cycle 4.
    req = 2'b01; req_we = 2'b00; req_addr[31:0] = 32'h100;
    run_txn(3, 32'hDEADBEEF, 0, 0);
    check("t1_issue", r_issue, 1);
    check("t1_nvalid", r_nvalid, 1);
    check("t1_gnt", r_gnt, 2'b01);
    check("t1_addr", r_addr, 32'h100);
    check("t1_pop", r_pop, 5);
    check("t1_npop", r_npop, 1);
    check("t1_take_first", r_take_first, 5);
    check("t1_take_last", r_take_last, 14);
    check("t1_ntake", r_ntake, 10);
    check("t1_rsp_cycle", r_rsp_c, 15);
    check("t1_rsp", {r_rsp, r_err}, {2'b01, 1'b0});
    check("t1_rdata", r_rdata, 32'hDEADBEEF);
    req = '0;
    step();
    check("t1_idle", {busy, gnt}, '0);

    // Fresh priority, both requesting continuously: strict alternation, back-to-back.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 2'b11; req_addr = {32'h200, 32'h300};
    for (int i = 0; i < 4; i++) begin
      run_txn(2, 32'(i), 0, 0);
      check("t2_gnt", r_gnt, (i % 2 == 1) ? 2'b10 : 2'b01);
      check("t2_rsp", r_rsp, r_gnt);
      check("t2_issue", r_issue, (i == 0) ? 1 : 2);
      check("t2_rsp_cycle", r_rsp_c - r_issue, 13);
    end
    req = '0;
    step();

    // Timeout: no mem_done ever.
    req = 2'b01;
    run_txn(-1, 32'h0, 0, 0);
    check("t3_issue", r_issue, 1);
    check("t3_rsp_cycle", r_rsp_c, 18);
    check("t3_rsp", {r_rsp, r_err}, {2'b01, 1'b1});
    check("t3_no_xfer", {r_ntake[7:0], r_npop[7:0]}, '0);
    check("t3_rdata_kept", r_rdata, 32'h3);
    req = '0;
    step();

    // bus_busy held in IDLE blocks the grant, then a 3-cycle stall mid-XFER.
    bus_busy = 1'b1; req = 2'b01;
    for (k = 0; k < 4; k++) begin
      step();
      check("t4_blocked", {busy, gnt}, '0);
    end
    bus_busy = 1'b0;
    run_txn(3, 32'h55AA, 6, 3);
    check("t4_issue", r_issue, 1);
    check("t4_take_first", r_take_first, 5);
    check("t4_take_last", r_take_last, 17);
    check("t4_ntake", r_ntake, 13);
    check("t4_npop", r_npop, 1);
    check("t4_rsp_cycle", r_rsp_c, 18);
    check("t4_rsp", {r_rsp, r_err, r_rdata}, {2'b01, 1'b0, 32'h55AA});
    req = '0;
    step();

    // Reset asserted during XFER, then a requester-1 transaction.
    req = 2'b01; mem_done = 1'b1;
    k = 0;
    while (!taking && k < 50) begin
      step();
      k++;
    end
    mem_done = 1'b0;
    check("t5_reach_xfer", taking, 1'b1);
    step(); step();
    rst_n = 1'b0;
    #1;
    check("t5_rst_ctl", {gnt, mem_valid, mem_we, taking, pop, rsp_valid, rsp_err, busy}, '0);
    check("t5_rst_data", {mem_addr, mem_wdata, rsp_rdata}, '0);
    req = 2'b10;
    step();
    rst_n = 1'b1;
    run_txn(2, 32'hCAFE0001, 0, 0);
    check("t5_issue", r_issue, 1);
    check("t5_gnt", r_gnt, 2'b10);
    check("t5_rsp", {r_rsp, r_err, r_rdata}, {2'b10, 1'b0, 32'hCAFE0001});
    req = '0;
    step();

    // Write from requester 1: command latched, read data left untouched.
    req = 2'b10; req_we = 2'b10; req_addr[63:32] = 32'h40; req_wdata[63:32] = 32'h1234;
    run_txn(2, 32'hFFFF0000, 0, 0);
    check("t6_cmd", {r_gnt, r_we, r_addr, r_wdata}, {2'b10, 1'b1, 32'h40, 32'h1234});
    check("t6_rsp", {r_rsp, r_err}, {2'b10, 1'b0});
    check("t6_rdata_kept", r_rdata, 32'hCAFE0001);
    req = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Round-robin arbiter and transaction sequencer that shares the single DRAM channel between NREQ cache-side requesters (I-cache and D-cache miss paths by default). It sits between the caches and Memory_controller/DRAM. It serialises one transaction at a time through issue, wait-for-done, transfer window and response. A per-transaction timeout guarantees forward progress when DRAM never signals done.

## Interface
- NREQ, 2, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- XFER_CYCLES, 10, length of the transfer window after mem_done (>=1)
- TIMEOUT, 64, max WAIT cycles before error (>=2)

- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level; held until its rsp_valid
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  flattened write data
- bus_busy  in  1  processor driving the shared bus; blocks new grants, freezes XFER
- mem_done  in  1  DRAM completion, sampled in WAIT only
- mem_rdata  in  DW  DRAM read data, valid with mem_done
- gnt  out  NREQ  one-hot grant, held from ISSUE through RESP
- mem_valid  out  1  one-cycle command strobe
- mem_we, mem_addr, mem_wdata  out  1/AW/DW  latched command of winner
- taking  out  1  high during every XFER cycle
- pop  out  1  one-cycle pulse in the first XFER cycle (queue dequeue)
- rsp_valid  out  NREQ  one-hot one-cycle response pulse to winner
- rsp_err  out  1  qualifies rsp_valid; 1 = timed out
- rsp_rdata  out  DW  read data latched at mem_done
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, XFER, RESP. All outputs are decoded from registered state or come from registers; there are no combinational input-to-output paths.
- IDLE: if |req and !bus_busy, pick winner w by round robin from ptr+1 (mod NREQ). Latch we/addr/wdata of w, set gnt=1<<w, go ISSUE. Otherwise stay.
- ISSUE: mem_valid=1 for exactly one cycle. Clear timer. Go WAIT.
- WAIT: mem_done=1 -> latch mem_rdata (reads only; writes leave rsp_rdata unchanged), clear xcnt, go XFER. Else timer++. If timer==TIMEOUT-1 without done, set err, go RESP. mem_done on the final WAIT cycle wins over timeout.
- XFER: taking=1. pop=1 on the first XFER cycle only. xcnt increments on cycles with bus_busy=0. Leave to RESP on a cycle where xcnt==XFER_CYCLES-1 and bus_busy=0. bus_busy=1 holds xcnt and state.
- RESP: rsp_valid[w]=1, rsp_err=err, ptr<=w, clear err. Go IDLE; gnt drops on exit.
- mem_done in IDLE/ISSUE/XFER/RESP is ignored.
- Requester dropping req mid-transaction: the transaction still completes and the response is still pulsed.
- A new request arriving mid-transaction waits. At most one transaction is outstanding.
- Counters: timer ceil(log2 TIMEOUT) bits, xcnt ceil(log2 XFER_CYCLES) bits, ptr ceil(log2 NREQ) bits. None wraps: each is cleared on state entry.

## Timing
- Reset (async assert): state=IDLE, ptr=NREQ-1 (req[0] has first priority). gnt, rsp_valid=0; mem_valid, mem_we, taking, pop, rsp_err, busy=0; mem_addr, mem_wdata, rsp_rdata=0. Reset mid-transaction aborts it with no response pulse.
- req sampled in cycle 0 -> gnt and mem_valid in cycle 1 -> WAIT from cycle 2.
- mem_done in cycle k (WAIT) -> XFER cycles k+1..k+XFER_CYCLES (no bus_busy) -> rsp_valid in k+XFER_CYCLES+1 -> IDLE in the next cycle.
- Back-to-back: next grant is at earliest 2 cycles after rsp_valid (the IDLE cycle decides, then ISSUE).

## Test plan
- Single read, req[0], addr 0x100, mem_done in cycle 4 with rdata 0xDEADBEEF -> mem_valid in cycle 1 only; pop in cycle 5; taking in cycles 5..14; rsp_valid=01 in cycle 15 with rsp_rdata 0xDEADBEEF, rsp_err=0.
- req=11 held continuously, done 2 cycles after each ISSUE -> grants alternate 01,10,01,10; no requester is granted twice in a row.
- No mem_done, TIMEOUT=16 -> WAIT cycles 2..17; rsp_valid with rsp_err=1 in cycle 18; taking and pop never assert.
- bus_busy high in IDLE with req pending -> no gnt until bus_busy falls. bus_busy high for 3 cycles mid-XFER -> taking window extends from 10 to 13 cycles; pop still single.
- rst_n low during XFER -> all outputs 0 immediately. After release with req[1] only -> gnt=10, full transaction completes.
- Write req[1], addr 0x40, wdata 0x1234 -> mem_we=1, mem_addr=0x40, mem_wdata=0x1234 with mem_valid; rsp_rdata keeps its prior value.
